// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave register-file memory with a fixed wait-state count.
//
// Every ACCESS phase inserts WAIT_STATES cycles with pready low before the
// completion cycle. pready comes only from registered state, so bus inputs
// never reach it combinationally. Address, direction and write data are
// captured in the setup phase, and the rest of the transfer uses those
// captured values.
//
// Optional build macro: APB_SLVERR_EN
//   defined   - addresses >= DEPTH complete with pslverr=1; writes are dropped
//               and reads return 0.
//   undefined - pslverr is tied 0 and addresses alias onto the word index.
//
// Ports:
//   clk      in   bus clock, rising edge
//   reset    in   asynchronous, active-high reset
//   paddr    in   transfer address (addrWidth)
//   pwrite   in   1 = write, 0 = read
//   psel     in   slave select
//   penable  in   access-phase strobe
//   pwdata   in   write data (dataWidth)
//   prdata   out  registered read data, valid with pready on a read
//   pready   out  transfer completion
//   pslverr  out  transfer error, valid with pready
module apb_slave_mem #(
    parameter int unsigned addrWidth   = 8,
    parameter int unsigned dataWidth   = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [addrWidth-1:0] paddr,
    input  logic                 pwrite,
    input  logic                 psel,
    input  logic                 penable,
    input  logic [dataWidth-1:0] pwdata,
    output logic [dataWidth-1:0] prdata,
    output logic                 pready,
    output logic                 pslverr
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [addrWidth-1:0] addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic [dataWidth-1:0] wdata_q, wdata_d;

    logic [dataWidth-1:0] mem [DEPTH];
    logic [dataWidth-1:0] prdata_q;

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 addr_err_q, addr_err_d;
    logic                 commit_c, rd_load_c;

    assign idx_q = addr_q[IDX_W-1:0];
    assign idx_d = addr_d[IDX_W-1:0];

`ifdef APB_SLVERR_EN
    // Upper address bits only feed the range check.
    assign addr_err_q = (addr_q >= addrWidth'(DEPTH));
    assign addr_err_d = (addr_d >= addrWidth'(DEPTH));
`else
    logic addr_hi_unused;
    assign addr_err_q     = 1'b0;
    assign addr_err_d     = 1'b0;
    assign addr_hi_unused = ^addr_q[addrWidth-1:IDX_W];
`endif

    // State register together with the wait counter and the setup-phase capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic. penable in IDLE without a setup phase is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    addr_d  = paddr;
                    wr_d    = pwrite;
                    wdata_d = pwdata;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath strobes. prdata is loaded on the edge that enters
    // the completion cycle, so it is valid throughout the pready cycle.
    always_comb begin
        pready    = (state_q == ACCESS) && (cnt_q == '0);
        pslverr   = pready && addr_err_q;
        commit_c  = pready && psel && wr_q && !addr_err_q;
        rd_load_c = (state_d == ACCESS) && (cnt_d == '0) && !wr_d;
    end

    // Memory array and read-data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
            prdata_q <= '0;
        end else begin
            if (commit_c) begin
                mem[idx_q] <= wdata_q;
            end
            if (rd_load_c) begin
                prdata_q <= addr_err_d ? '0 : mem[idx_d];
            end
        end
    end

    assign prdata = prdata_q;

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB slave register-file memory that consumes the bus driven through the team's APB interface (paddr, pwrite, psel, penable, pwdata) and returns prdata/pready. It is the DUT stage directly downstream of the interface's driver clocking block, and its outputs are sampled by the output monitor. The block has a fixed, parameterised wait-state count and address range checking.

Parameters:
addrWidth, 8, width of paddr
dataWidth, 32, width of pwdata/prdata and of each memory word
DEPTH, 16, number of words; word index is paddr[$clog2(DEPTH)-1:0]; valid addresses are 0..DEPTH-1
WAIT_STATES, 2, pready-low cycles inserted in every ACCESS phase (0 = zero-wait)

Ports:
clk  input  1  bus clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
paddr  input  addrWidth  transfer address
pwrite  input  1  1 = write, 0 = read
psel  input  1  slave select
penable  input  1  access-phase strobe
pwdata  input  dataWidth  write data
prdata  output  dataWidth  read data, valid while pready=1 on a read
pready  output  1  transfer completion
pslverr  output  1  transfer error, valid while pready=1

Behaviour:
- Reset (async, active-high) forces the following: state=IDLE, wait counter=0, pready=0, prdata=0, pslverr=0, all DEPTH memory words=0, captured addr/data/dir regs=0. Reset asserted mid-transfer aborts the transfer and commits no write.
- FSM has two states: IDLE and ACCESS.
- IDLE, psel=1 and penable=0 (setup phase): capture paddr, pwrite and pwdata into the addr_q/wr_q/wdata_q regs. Load cnt=WAIT_STATES and go to ACCESS.
- IDLE, penable=1 without a preceding setup: treat as a protocol violation. Ignore it, stay in IDLE, keep pready=0.
- ACCESS, psel=1 and cnt!=0: pready=0 and cnt decrements.
- ACCESS, psel=1 and cnt==0: pready=1 for exactly one cycle. pready is decoded from registered state (state==ACCESS && cnt==0). Inputs are not combinationally fed through to it.
- Completing write: mem[addr_q] is written with wdata_q at the posedge where pready=1.
- Completing read: prdata=mem[addr_q] while pready=1.
- Completion edge: next state is IDLE. A new setup phase may appear in the very next cycle (back-to-back transfers). Minimum transfer length is 2+WAIT_STATES cycles.
- ACCESS, psel deasserted before completion: abort. Go to IDLE, no write is committed, pready stays 0.
- Inputs that change during ACCESS are ignored, because the captured values are used.
- prdata is registered. It holds its last read value outside read completions and is not updated by writes.
- Word index truncation: upper paddr bits above the index are used only for the range check.

Optional Feature:
Macro APB_SLVERR_EN.
- Defined: a transfer with addr_q >= DEPTH completes with normal wait-state timing and pslverr=1 in the pready cycle. A write to such an address is dropped. A read returns prdata=0.
- Not defined: pslverr is tied 0 and out-of-range addresses alias onto the truncated word index.

Test Plan:
- Write-then-read, WAIT_STATES=2: write paddr=0x03, pwdata=0xDEADBEEF, then read 0x03 -> each transfer is 4 cycles with pready high in cycle 4 only; read prdata=0xDEADBEEF, pslverr=0.
- Back-to-back writes to 0x00 and 0x01 (0x11111111, 0x22222222), a setup immediately after each completion, then reads of both -> no idle cycle is required and the values are returned correctly.
- Abort: setup write 0x05=0xA5A5A5A5, then drop psel in the first ACCESS cycle; later read 0x05 -> pready never rose during the abort, and the read returns 0x00000000.
- Async reset mid-ACCESS (reset high between clock edges) -> pready, prdata and pslverr go to 0 immediately; a following read of a previously written word returns 0.
- Protocol violation: penable=1 with psel=1 and no setup cycle -> pready stays 0 and the FSM stays in IDLE.
- APB_SLVERR_EN defined: write 0x20=0x12345678 with DEPTH=16 -> pready high in cycle 4 with pslverr=1; a subsequent read of 0x00 returns the unchanged value.
